// File: rtl/dcache_victim_sel.sv
// D-cache victim selector: per-set tree-PLRU state, invalid-way preference and
// dirty lookup, returning victim way/dirty/tag over a valid/ready handshake.
module dcache_victim_sel #(
    parameter int unsigned WAYS  = 8,
    parameter int unsigned SETS  = 64,
    parameter int unsigned TAG_W = 44,
    localparam int unsigned IDX_W = $clog2(SETS),
    localparam int unsigned WAY_W = $clog2(WAYS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [IDX_W-1:0]      req_index_i,
    input  logic [WAYS*TAG_W-1:0] req_tag_all_i,
    input  logic [WAYS-1:0]       req_line_valid_i,
    output logic                  dirty_rd_valid_o,
    output logic [IDX_W-1:0]      dirty_rd_index_o,
    input  logic [WAYS-1:0]       dirty_rd_data_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [WAY_W-1:0]      resp_way_o,
    output logic                  resp_dirty_o,
    output logic [TAG_W-1:0]      resp_tag_o,
    input  logic                  touch_valid_i,
    input  logic [IDX_W-1:0]      touch_index_i,
    input  logic [WAY_W-1:0]      touch_way_i
);

    localparam int unsigned NODES = WAYS - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    req_ready_q, req_ready_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WAYS*TAG_W-1:0]   tags_q, tags_d;
    logic [WAYS-1:0]         lv_q, lv_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [WAY_W-1:0]        resp_way_q, resp_way_d;
    logic                    resp_dirty_q, resp_dirty_d;
    logic [TAG_W-1:0]        resp_tag_q, resp_tag_d;
    logic [NODES-1:0]        plru_q [SETS];

    logic                    fill_c;
    logic [WAY_W-1:0]        plru_way_c;
    logic [WAY_W-1:0]        inv_way_c;
    logic                    any_inv_c;
    logic [WAY_W-1:0]        victim_c;
    logic                    victim_dirty_c;
    logic [TAG_W-1:0]        victim_tag_c;
    logic [NODES-1:0]        fill_bits_c;
    logic [NODES-1:0]        touch_base_c;
    logic [NODES-1:0]        touch_bits_c;

    // Point every node on the way's path away from that way.
    function automatic logic [NODES-1:0] mark_mru(input logic [NODES-1:0] bits,
                                                  input logic [WAY_W-1:0] way);
        logic [NODES-1:0] r;
        int unsigned      node;
        r    = bits;
        node = 0;
        for (int l = int'(WAY_W) - 1; l >= 0; l--) begin
            r[WAY_W'(node)] = ~way[l];
            node = 2 * node + 1 + 32'(way[l]);
        end
        return r;
    endfunction

    assign req_ready_o      = req_ready_q;
    assign dirty_rd_valid_o = req_valid_i & req_ready_q;
    assign dirty_rd_index_o = req_index_i;
    assign resp_valid_o     = resp_valid_q;
    assign resp_way_o       = resp_way_q;
    assign resp_dirty_o     = resp_dirty_q;
    assign resp_tag_o       = resp_tag_q;

    // Tree walk of the captured set; upper way-number bits come from nodes nearer the root.
    always_comb begin
        int unsigned node;
        logic        b;
        plru_way_c = '0;
        node       = 0;
        b          = 1'b0;
        for (int l = int'(WAY_W) - 1; l >= 0; l--) begin
            b             = plru_q[idx_q][WAY_W'(node)];
            plru_way_c[l] = b;
            node          = 2 * node + 1 + 32'(b);
        end
    end

    // Lowest-numbered invalid way overrides the PLRU choice.
    always_comb begin
        inv_way_c = '0;
        any_inv_c = 1'b0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!lv_q[w]) begin
                inv_way_c = WAY_W'(w);
                any_inv_c = 1'b1;
            end
        end
        victim_c       = any_inv_c ? inv_way_c : plru_way_c;
        victim_dirty_c = any_inv_c ? 1'b0 : dirty_rd_data_i[victim_c];
        victim_tag_c   = tags_q[32'(victim_c) * TAG_W +: TAG_W];
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        idx_d        = idx_q;
        tags_d       = tags_q;
        lv_d         = lv_q;
        resp_valid_d = resp_valid_q;
        resp_way_d   = resp_way_q;
        resp_dirty_d = resp_dirty_q;
        resp_tag_d   = resp_tag_q;
        fill_c       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    idx_d       = req_index_i;
                    tags_d      = req_tag_all_i;
                    lv_d        = req_line_valid_i;
                    req_ready_d = 1'b0;
                    state_d     = READ;
                end
            end
            READ: begin
                resp_way_d   = victim_c;
                resp_dirty_d = victim_dirty_c;
                resp_tag_d   = victim_tag_c;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready_i) begin
                    fill_c       = 1'b1;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            idx_q        <= '0;
            tags_q       <= '0;
            lv_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_way_q   <= '0;
            resp_dirty_q <= 1'b0;
            resp_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            idx_q        <= idx_d;
            tags_q       <= tags_d;
            lv_q         <= lv_d;
            resp_valid_q <= resp_valid_d;
            resp_way_q   <= resp_way_d;
            resp_dirty_q <= resp_dirty_d;
            resp_tag_q   <= resp_tag_d;
        end
    end

    // A touch to the filled set builds on the fill result so it wins on shared nodes.
    always_comb begin
        fill_bits_c  = mark_mru(plru_q[idx_q], resp_way_q);
        touch_base_c = (fill_c && (touch_index_i == idx_q)) ? fill_bits_c
                                                            : plru_q[touch_index_i];
        touch_bits_c = mark_mru(touch_base_c, touch_way_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < int'(SETS); s++) begin
                plru_q[s] <= '0;
            end
        end else begin
            if (fill_c) begin
                plru_q[idx_q] <= fill_bits_c;
            end
            if (touch_valid_i) begin
                plru_q[touch_index_i] <= touch_bits_c;
            end
        end
    end

endmodule

// File: tb/tb_dcache_victim_sel.sv
// Bench for dcache_victim_sel: reference PLRU model feeds a scoreboard queue,
// a negedge monitor compares every presented response and handshake flag.
module tb_dcache_victim_sel;

    localparam int unsigned WAYS  = 8;
    localparam int unsigned SETS  = 64;
    localparam int unsigned TAG_W = 44;
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned WAY_W = $clog2(WAYS);

    logic                  clk = 1'b0;
    logic                  rst_ni;
    logic                  req_valid;
    logic                  req_ready_o;
    logic [IDX_W-1:0]      req_index;
    logic [WAYS*TAG_W-1:0] req_tag_all;
    logic [WAYS-1:0]       req_line_valid;
    logic                  dirty_rd_valid_o;
    logic [IDX_W-1:0]      dirty_rd_index_o;
    logic [WAYS-1:0]       dirty_rd_data;
    logic                  resp_valid_o;
    logic                  resp_ready;
    logic [WAY_W-1:0]      resp_way_o;
    logic                  resp_dirty_o;
    logic [TAG_W-1:0]      resp_tag_o;
    logic                  touch_valid;
    logic [IDX_W-1:0]      touch_index;
    logic [WAY_W-1:0]      touch_way;

    always #5 clk = ~clk;

    dcache_victim_sel #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready_o),
        .req_index_i      (req_index),
        .req_tag_all_i    (req_tag_all),
        .req_line_valid_i (req_line_valid),
        .dirty_rd_valid_o (dirty_rd_valid_o),
        .dirty_rd_index_o (dirty_rd_index_o),
        .dirty_rd_data_i  (dirty_rd_data),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready),
        .resp_way_o       (resp_way_o),
        .resp_dirty_o     (resp_dirty_o),
        .resp_tag_o       (resp_tag_o),
        .touch_valid_i    (touch_valid),
        .touch_index_i    (touch_index),
        .touch_way_i      (touch_way)
    );

    typedef struct {
        int               way;
        bit               dirty;
        logic [TAG_W-1:0] tag;
    } exp_t;

    typedef struct {
        bit               chk;
        int               way;
        bit               dirty;
        logic [TAG_W-1:0] tag;
    } dir_t;

    exp_t exp_q[$];
    dir_t dir_q[$];

    int   errors = 0;
    int   checks = 0;
    bit   done = 1'b0;
    bit   rand_touch = 1'b0;

    logic [WAYS-1:0] dirty_mem [SETS];

    // Dirty array: read data appears the cycle after the index is presented.
    always @(posedge clk) dirty_rd_data <= dirty_mem[req_index];

    // Reference model: PLRU bits per set, node n covers a way range that halves per level.
    int                    m_plru [SETS][WAYS];
    int                    m_phase;
    int                    m_idx;
    int                    m_way;
    logic [WAYS-1:0]       m_lv;
    logic [WAYS-1:0]       m_dirty;
    logic [WAYS*TAG_W-1:0] m_tags;
    bit                    m_fill;
    bit                    m_found;
    exp_t                  m_e;

    function automatic int plru_victim(input int s);
        int lo, size, node;
        lo = 0; size = WAYS; node = 0;
        while (size > 1) begin
            size = size / 2;
            if (m_plru[s][node] != 0) begin
                lo   = lo + size;
                node = 2 * node + 2;
            end else begin
                node = 2 * node + 1;
            end
        end
        return lo;
    endfunction

    function automatic void make_mru(input int s, input int w);
        int lo, size, node;
        lo = 0; size = WAYS; node = 0;
        while (size > 1) begin
            size = size / 2;
            if (w < lo + size) begin
                m_plru[s][node] = 1;
                node = 2 * node + 1;
            end else begin
                m_plru[s][node] = 0;
                lo   = lo + size;
                node = 2 * node + 2;
            end
        end
    endfunction

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            foreach (m_plru[s, n]) m_plru[s][n] = 0;
            m_phase = 0;
        end else begin
            m_fill = 1'b0;
            case (m_phase)
                0: if (req_valid) begin
                    m_idx   = int'(req_index);
                    m_lv    = req_line_valid;
                    m_tags  = req_tag_all;
                    m_dirty = dirty_mem[req_index];
                    m_phase = 1;
                end
                1: begin
                    m_found = 1'b0;
                    for (int w = 0; w < WAYS; w++) begin
                        if (!m_found && !m_lv[w]) begin
                            m_found = 1'b1;
                            m_e.way = w;
                        end
                    end
                    if (m_found) begin
                        m_e.dirty = 1'b0;
                    end else begin
                        m_e.way   = plru_victim(m_idx);
                        m_e.dirty = m_dirty[m_e.way];
                    end
                    m_e.tag = m_tags[m_e.way * TAG_W +: TAG_W];
                    exp_q.push_back(m_e);
                    m_way   = m_e.way;
                    m_phase = 2;
                end
                default: if (resp_ready) begin
                    m_fill  = 1'b1;
                    m_phase = 0;
                end
            endcase
            if (m_fill) make_mru(m_idx, m_way);
            if (touch_valid) make_mru(int'(touch_index), int'(touch_way));
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: flags every cycle, response contents whenever a response is presented.
    always @(negedge clk) begin
        if (!rst_ni) begin
            chk("reset_resp_valid", 64'(resp_valid_o), 64'd0);
            chk("reset_resp_fields", {19'd0, resp_tag_o, resp_way_o, resp_dirty_o}, 64'd0);
            exp_q.delete();
            dir_q.delete();
        end else begin
            chk("resp_valid", 64'(resp_valid_o), 64'(m_phase == 2));
            chk("req_ready", 64'(req_ready_o), 64'(m_phase == 0));
            chk("dirty_rd_valid", 64'(dirty_rd_valid_o), 64'(req_valid && m_phase == 0));
            chk("dirty_rd_index", 64'(dirty_rd_index_o), 64'(req_index));
            if (resp_valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: way=%0d with no expected entry", resp_way_o);
                end else begin
                    chk("resp_way", 64'(resp_way_o), 64'(exp_q[0].way));
                    chk("resp_dirty", 64'(resp_dirty_o), 64'(exp_q[0].dirty));
                    chk("resp_tag", 64'(resp_tag_o), 64'(exp_q[0].tag));
                end
                if (dir_q.size() != 0 && dir_q[0].chk) begin
                    chk("directed_way", 64'(resp_way_o), 64'(dir_q[0].way));
                    chk("directed_dirty", 64'(resp_dirty_o), 64'(dir_q[0].dirty));
                    chk("directed_tag", 64'(resp_tag_o), 64'(dir_q[0].tag));
                end
                if (resp_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    if (dir_q.size() != 0) void'(dir_q.pop_front());
                end
            end
        end
        if (done) begin
            chk("queue_drained", 64'(exp_q.size()), 64'd0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_touch) begin
            touch_valid = ($urandom_range(0, 2) == 0);
            touch_index = IDX_W'($urandom_range(0, 3));
            touch_way   = WAY_W'($urandom_range(0, WAYS - 1));
        end
    endtask

    task automatic touch(input int idx, input int way);
        touch_valid = 1'b1;
        touch_index = IDX_W'(idx);
        touch_way   = WAY_W'(way);
        step();
        touch_valid = 1'b0;
    endtask

    function automatic logic [WAYS*TAG_W-1:0] rand_tags();
        logic [WAYS*TAG_W-1:0] t;
        for (int w = 0; w < WAYS; w++) t[w * TAG_W +: TAG_W] = TAG_W'({$urandom, $urandom});
        return t;
    endfunction

    task automatic issue(input int idx, input logic [WAYS-1:0] lv,
                         input logic [WAYS*TAG_W-1:0] tags, input int stall,
                         input bit hold_req, input bit dchk, input int ew,
                         input bit ed, input logic [TAG_W-1:0] et);
        dir_t d;
        int   n;
        d.chk = dchk; d.way = ew; d.dirty = ed; d.tag = et;
        dir_q.push_back(d);
        req_valid      = 1'b1;
        req_index      = IDX_W'(idx);
        req_line_valid = lv;
        req_tag_all    = tags;
        step();
        if (!hold_req) req_valid = 1'b0;
        n = 0;
        while (!resp_valid_o) begin
            n++;
            if (n > 10) begin
                $display("FAIL resp_timeout: no resp_valid for index %0d", idx);
                $fatal(1, "response timeout");
            end
            step();
        end
        for (int i = 0; i < stall; i++) step();
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic reset_mid(input int idx, input int wait_cycles);
        req_valid      = 1'b1;
        req_index      = IDX_W'(idx);
        req_line_valid = '1;
        req_tag_all    = rand_tags();
        step();
        req_valid = 1'b0;
        for (int i = 0; i < wait_cycles; i++) step();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WAYS*TAG_W-1:0] tags;
        rst_ni = 1'b0;
        req_valid = 1'b0; req_index = '0; req_tag_all = '0; req_line_valid = '0;
        resp_ready = 1'b0; touch_valid = 1'b0; touch_index = '0; touch_way = '0;
        for (int s = 0; s < SETS; s++) dirty_mem[s] = '0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        step();

        // All valid, fresh set: PLRU all-zero points at way 0.
        dirty_mem[5] = 8'h01;
        tags = rand_tags();
        tags[0 +: TAG_W] = TAG_W'(44'h123);
        issue(5, 8'hFF, tags, 0, 1'b0, 1'b1, 0, 1'b1, TAG_W'(44'h123));

        // Invalid way 3 preferred, its dirty bit ignored.
        dirty_mem[6] = 8'h08;
        tags = rand_tags();
        issue(6, 8'b1111_0111, tags, 0, 1'b0, 1'b1, 3, 1'b0, tags[3 * TAG_W +: TAG_W]);

        // Touches on index 0 steer the tree.
        dirty_mem[0] = 8'h10;
        for (int w = 0; w < 4; w++) touch(0, w);
        tags = rand_tags();
        issue(0, 8'hFF, tags, 0, 1'b0, 1'b1, 4, 1'b1, tags[4 * TAG_W +: TAG_W]);
        for (int w = 4; w < 8; w++) touch(0, w);
        tags = rand_tags();
        issue(0, 8'hFF, tags, 0, 1'b0, 1'b1, 0, 1'b0, tags[0 +: TAG_W]);

        // Back-to-back requests: fill update moves the second victim.
        tags = rand_tags();
        issue(9, 8'hFF, tags, 0, 1'b0, 1'b1, 0, 1'b0, tags[0 +: TAG_W]);
        issue(9, 8'hFF, tags, 0, 1'b0, 1'b1, 4, 1'b0, tags[4 * TAG_W +: TAG_W]);

        // Stalled response with a request pending behind it.
        dirty_mem[10] = 8'hA5;
        tags = rand_tags();
        issue(10, 8'hFF, tags, 5, 1'b1, 1'b1, 0, 1'b1, tags[0 +: TAG_W]);

        // Reset while in RESP clears PLRU state and drops the fill.
        reset_mid(9, 2);
        tags = rand_tags();
        issue(9, 8'hFF, tags, 0, 1'b0, 1'b1, 0, 1'b0, tags[0 +: TAG_W]);

        // Randomised traffic on a few colliding sets with concurrent touches.
        rand_touch = 1'b1;
        for (int it = 0; it < 400; it++) begin
            int idx;
            logic [WAYS-1:0] lv;
            idx = $urandom_range(0, 3);
            lv  = ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : '1;
            dirty_mem[idx] = WAYS'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                reset_mid(idx, $urandom_range(0, 2));
            end else begin
                issue(idx, lv, rand_tags(), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 1'b0, 0, 1'b0, '0);
            end
        end
        rand_touch  = 1'b0;
        touch_valid = 1'b0;
        step();
        step();
        done = 1'b1;
        forever @(posedge clk);
    end

endmodule

// File: doc/dcache_victim_sel.md
# dcache_victim_sel

Parametrised D-cache victim selector. It owns the per-set tree-PLRU state, reads the dirty array, and returns victim way, dirty flag and victim tag to the cache controller over a valid/ready handshake. Invalid ways are preferred over PLRU choice, and PLRU state is updated both on controller hit-touches and on victim fills. It sits between the D-cache control FSM and the dirty array, and replaces the fixed 8-way selector with its external PLRU.

## Interface
- WAYS, 8, associativity; power of two, 2..16
- SETS, 64, number of sets; power of two
- TAG_W, 44, tag width per way
- IDX_W, log2(SETS), set index width
- WAY_W, log2(WAYS), way number width
- clock  in  1  clock; all state on the rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  victim request from ctrl
- req_ready  out  1  request accepted; high only in IDLE
- req_index  in  IDX_W  set index
- req_tag_all  in  WAYS*TAG_W  tags of all ways; way w at [w*TAG_W +: TAG_W]
- req_line_valid  in  WAYS  line-valid bits of the set
- dirty_rd_valid  out  1  dirty array read strobe; equals req_valid & req_ready
- dirty_rd_index  out  IDX_W  equals req_index
- dirty_rd_data  in  WAYS  dirty bits, returned in the cycle after dirty_rd_valid
- resp_valid  out  1  victim result valid
- resp_ready  in  1  ctrl consumes result
- resp_way  out  WAY_W  victim way
- resp_dirty  out  1  victim needs writeback
- resp_tag  out  TAG_W  tag of the victim way
- touch_valid  in  1  hit update
- touch_index  in  IDX_W  set of the hit
- touch_way  in  WAY_W  way hit; marked MRU

## Operation
- FSM states:
  - IDLE: req_ready=1. On req_valid, capture index, tag_all and line_valid, then go to READ.
  - READ: dirty_rd_data is valid. Compute the victim, register resp_way, resp_dirty and resp_tag, then go to RESP.
  - RESP: resp_valid=1. On resp_ready, apply the fill update and go to IDLE.
- Victim rule:
  - If any captured line-valid bit is 0, the victim is the lowest-numbered invalid way and resp_dirty=0.
  - Otherwise the victim is the tree-PLRU way and resp_dirty = dirty_rd_data[way].
- PLRU tree: WAYS-1 bits per set, heap-ordered (node 0 is the root; children of node n are 2n+1 and 2n+2).
  - Walk: bit 0 selects the lower half, bit 1 the upper half.
  - Mark MRU of way w: set every node on w's path to point away from w.
- Fill update: on the resp handshake, mark resp_way MRU in the captured set.
- Touch update: whenever touch_valid=1, in any state, mark touch_way MRU in touch_index.
- Same cycle, same set, fill and touch: apply the fill first, then the touch; the touch wins on shared nodes. Different sets: apply both.
- The PLRU read in READ sees all updates committed by earlier clock edges.
- resp outputs hold stable while resp_valid=1 and resp_ready=0.
- req_valid is ignored outside IDLE.

## Timing
- Request accepted at edge T. Result registered at edge T+1. resp_valid=1 from cycle T+1 (after the edge) until the handshake.
- Minimum request-to-request spacing is 3 cycles, when resp_ready=1 immediately.
- Reset asserted, immediately and at any time:
  - state=IDLE, resp_valid=0, resp_way=0, resp_dirty=0, resp_tag=0
  - all PLRU bits cleared to 0
  - an in-flight request is dropped with no fill update
- req_ready=1 and dirty_rd_valid follows req_valid from the first cycle after reset deasserts.
- A touch arriving on the same edge as an accepted request to the same set is visible to that request's victim choice.

## Test plan
- After reset, req index 5, line_valid=8'hFF, dirty_rd_data=8'h01, way0 tag=44'h123 -> resp_valid at T+1, resp_way=0, resp_dirty=1, resp_tag=44'h123.
- line_valid=8'b1111_0111 with dirty_rd_data[3]=1 -> resp_way=3, resp_dirty=0.
- Index 0 all valid, touches to ways 0,1,2,3, then req -> resp_way=4. Then touches 4..7 on top of that, then req -> resp_way=0.
- Two back-to-back reqs to index 9, all valid, no touches -> first resp_way=0, second resp_way=4 (fill update applied).
- resp_ready held low 5 cycles while req_valid=1 -> resp outputs constant, req_ready=0, dirty_rd_valid=0, no second request accepted.
- Reset asserted while in RESP -> resp_valid=0 at once. After release, a req to index 9 with all valid -> resp_way=0.
